// File: rtl/hash_pipe_arbiter.sv
// rtl/hash_pipe_arbiter.sv - round-robin sharing of one pipelined hash unit with a credit-protected response FIFO
//
// Optional build macro: HASH_ARB_PERF_CNT_EN adds the issue_cnt / stall_cnt ports.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_addr  per-requester request valid and packed addresses
//   req_ready           one-hot grant back to the requesters
//   hash_addr           registered address driven into the hash unit
//   hash_value          hash unit result, HASH_LATENCY cycles after its sample edge
//   rsp_valid/rsp_ready response handshake at the FIFO head
//   rsp_id/addr/hash    requester ID, original address and hash of the head entry
//   busy                any request in flight or buffered
//   issue_cnt/stall_cnt (HASH_ARB_PERF_CNT_EN) saturating grant and credit-stall counters
module hash_pipe_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_SIZE    = 22,
    parameter int W            = 4096,
    parameter int HASH_SIZE    = $clog2(W),
    parameter int HASH_LATENCY = 6,
    parameter int FIFO_DEPTH   = 8,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [ADDR_SIZE-1:0]         hash_addr,
    input  logic [HASH_SIZE-1:0]         hash_value,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [ADDR_SIZE-1:0]         rsp_addr,
    output logic [HASH_SIZE-1:0]         rsp_hash,
    output logic                         busy
`ifdef HASH_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                  issue_cnt,
    output logic [31:0]                  stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ID_W + ADDR_SIZE + HASH_SIZE;

    // Arbitration and credit state
    logic [ID_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0] used_q, used_d;
    logic [ADDR_SIZE-1:0] hash_addr_q, hash_addr_d;

    // Alignment shift register, stage k holds the request granted k+1 edges ago
    logic [HASH_LATENCY:0]                 stg_vld_q, stg_vld_d;
    logic [HASH_LATENCY:0][ID_W-1:0]       stg_id_q, stg_id_d;
    logic [HASH_LATENCY:0][ADDR_SIZE-1:0]  stg_addr_q, stg_addr_d;

    // Response FIFO
    logic [FIFO_DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                 credit_ok;
    logic                 found;
    logic                 grant;
    logic                 push;
    logic                 pop;
    logic [ID_W:0]        start;
    logic [ID_W:0]        cand;
    logic [2*NUM_REQ-1:0] dbl_valid;
    logic [NUM_REQ-1:0]   rot_valid;
    logic [ID_W-1:0]      grant_id;
    logic [ADDR_SIZE-1:0] grant_addr;

    // Round-robin search: rotate the request vector so the slot after the
    // last grant sits at bit 0, take the lowest set bit, then map it back.
    always_comb begin
        credit_ok = (used_q < CNT_W'(FIFO_DEPTH));
        start     = {1'b0, last_q} + (ID_W+1)'(1);
        dbl_valid = {req_valid, req_valid} >> start;
        rot_valid = dbl_valid[NUM_REQ-1:0];
        found     = 1'b0;
        cand      = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && rot_valid[j]) begin
                found = 1'b1;
                cand  = start + (ID_W+1)'(j);
            end
        end
        if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
        end
        grant_id  = cand[ID_W-1:0];
        grant     = found & credit_ok & rst_n;
        req_ready = '0;
        if (grant) begin
            req_ready[grant_id] = 1'b1;
        end
        grant_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                grant_addr = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
            end
        end
    end

    assign push      = stg_vld_q[HASH_LATENCY];
    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign {rsp_id, rsp_addr, rsp_hash} = mem_q[rd_ptr_q];
    assign hash_addr = hash_addr_q;
    assign busy      = (used_q != '0);

    always_comb begin
        last_d      = grant ? grant_id : last_q;
        hash_addr_d = grant ? grant_addr : '0;

        // A credit is held from grant until the response leaves the FIFO,
        // so a push can never find the FIFO full.
        used_d = used_q;
        if (grant && !pop) begin
            used_d = used_q + CNT_W'(1);
        end else if (!grant && pop) begin
            used_d = used_q - CNT_W'(1);
        end

        stg_vld_d[0]  = grant;
        stg_id_d[0]   = grant ? grant_id : '0;
        stg_addr_d[0] = grant ? grant_addr : '0;
        for (int k = 1; k <= HASH_LATENCY; k++) begin
            stg_vld_d[k]  = stg_vld_q[k-1];
            stg_id_d[k]   = stg_id_q[k-1];
            stg_addr_d[k] = stg_addr_q[k-1];
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {stg_id_q[HASH_LATENCY], stg_addr_q[HASH_LATENCY], hash_value};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= ID_W'(NUM_REQ - 1);
            used_q      <= '0;
            hash_addr_q <= '0;
            stg_vld_q   <= '0;
            stg_id_q    <= '0;
            stg_addr_q  <= '0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            last_q      <= last_d;
            used_q      <= used_d;
            hash_addr_q <= hash_addr_d;
            stg_vld_q   <= stg_vld_d;
            stg_id_q    <= stg_id_d;
            stg_addr_q  <= stg_addr_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef HASH_ARB_PERF_CNT_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (grant && (issue_cnt_q != '1)) begin
            issue_cnt_d = issue_cnt_q + 32'd1;
        end
        if ((|req_valid) && !credit_ok && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hash_pipe_arbiter.sv
// tb/tb_hash_pipe_arbiter.sv - directed self-checking bench for hash_pipe_arbiter
module tb_hash_pipe_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ADDR_SIZE = 22;
    localparam int HASH_SIZE = 12;
    localparam int HL        = 6;
    localparam int ENT_W     = 2 + ADDR_SIZE + HASH_SIZE;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [NUM_REQ-1:0]           req_valid = '0;
    logic [NUM_REQ*ADDR_SIZE-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]           req_ready;
    logic [ADDR_SIZE-1:0]         hash_addr;
    logic [HASH_SIZE-1:0]         hash_value;
    logic                         rsp_valid;
    logic                         rsp_ready = 1'b0;
    logic [1:0]                   rsp_id;
    logic [ADDR_SIZE-1:0]         rsp_addr;
    logic [HASH_SIZE-1:0]         rsp_hash;
    logic                         busy;
`ifdef HASH_ARB_PERF_CNT_EN
    logic [31:0]                  issue_cnt;
    logic [31:0]                  stall_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    hash_pipe_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .hash_addr  (hash_addr),
        .hash_value (hash_value),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_addr   (rsp_addr),
        .rsp_hash   (rsp_hash),
        .busy       (busy)
`ifdef HASH_ARB_PERF_CNT_EN
        ,
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    function automatic logic [HASH_SIZE-1:0] hash_fn(input logic [ADDR_SIZE-1:0] a);
        logic [31:0] t;
        t = {10'd0, a} * 32'h0000_9E37;
        return t[18:7] ^ t[11:0];
    endfunction

    // Hash unit model: samples hash_addr each edge, result visible HL edges after the grant edge
    logic [HL-1:0][HASH_SIZE-1:0] hpipe;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpipe <= '0;
        end else begin
            hpipe[0] <= hash_fn(hash_addr);
            for (int k = 1; k < HL; k++) hpipe[k] <= hpipe[k-1];
        end
    end
    assign hash_value = hpipe[HL-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic rand_addrs();
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_SIZE +: ADDR_SIZE] = ADDR_SIZE'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor, sampling just before each rising edge
    logic [ENT_W-1:0]     exp_q[$];
    int                   inflight = 0;
    int                   max_inflight = 0;
    logic                 prev_xfer = 1'b0;
    logic [ADDR_SIZE-1:0] prev_addr = '0;

    always begin
        logic [NUM_REQ-1:0]   xfer;
        logic [ADDR_SIZE-1:0] a;
        logic [ENT_W-1:0]     e;
        int                   id;
        @(negedge clk);
        #3;
        if (!rst_n) begin
            exp_q.delete();
            inflight  = 0;
            prev_xfer = 1'b0;
        end else begin
            chk("hash_addr", 64'(hash_addr), prev_xfer ? 64'(prev_addr) : 64'd0);
            chk("req_ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL rsp_unexpected: got id %0d addr %0h, required no response", rsp_id, rsp_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_entry", 64'({rsp_id, rsp_addr, rsp_hash}), 64'(e));
                end
                inflight--;
            end
            xfer      = req_valid & req_ready;
            prev_xfer = (xfer != '0);
            if (xfer != '0) begin
                id = 0;
                for (int i = 0; i < NUM_REQ; i++) if (xfer[i]) id = i;
                a = req_addr[id*ADDR_SIZE +: ADDR_SIZE];
                exp_q.push_back({2'(id), a, hash_fn(a)});
                prev_addr = a;
                inflight++;
                if (inflight > max_inflight) max_inflight = inflight;
            end
        end
    end

    typedef struct {
        logic [NUM_REQ-1:0] rv;
        logic [NUM_REQ-1:0] exp_rdy;
    } arb_vec_t;

    arb_vec_t tbl [13];

    initial begin
        int exp_next;
        int xfers;
        int xfers2;

        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0001};
        tbl[2]  = '{4'b1111, 4'b0010};
        tbl[3]  = '{4'b1001, 4'b1000};
        tbl[4]  = '{4'b1001, 4'b0001};
        tbl[5]  = '{4'b0110, 4'b0010};
        tbl[6]  = '{4'b0000, 4'b0000};
        tbl[7]  = '{4'b0100, 4'b0100};
        tbl[8]  = '{4'b1001, 4'b1000};
        tbl[9]  = '{4'b1001, 4'b0001};
        tbl[10] = '{4'b0001, 4'b0001};
        tbl[11] = '{4'b1010, 4'b0010};
        tbl[12] = '{4'b0000, 4'b0000};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_hash_addr", 64'(hash_addr), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_fields", 64'({rsp_id, rsp_addr, rsp_hash}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef HASH_ARB_PERF_CNT_EN
        chk("rst_issue_cnt", 64'(issue_cnt), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst_n = 1'b1;

        // Arbitration table, including last grant 2 followed by 1001
        rsp_ready = 1'b1;
        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            req_valid = tbl[v].rv;
            rand_addrs();
            #1;
            chk($sformatf("arb_vec%0d", v), 64'(req_ready), 64'(tbl[v].exp_rdy));
        end
        @(negedge clk);
        req_valid = '0;
        repeat (12) @(negedge clk);
        #1;
        chk("arb_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("arb_busy_idle", 64'(busy), 64'd0);

        // Single request latency
        do_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010;
        req_addr  = '0;
        req_addr[1*ADDR_SIZE +: ADDR_SIZE] = 22'h00001;
        #1;
        chk("t1_ready", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("t1_busy_inflight", 64'(busy), 64'd1);
        chk("t1_rsp_valid_c1", 64'(rsp_valid), 64'd0);
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t1_rsp_valid_c%0d", k), 64'(rsp_valid), 64'd0);
        end
        @(negedge clk);
        #1;
        chk("t1_rsp_valid_c8", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_id", 64'(rsp_id), 64'd1);
        chk("t1_rsp_addr", 64'(rsp_addr), 64'h1);
        chk("t1_rsp_hash", 64'(rsp_hash), 64'(hash_fn(22'h1)));
        chk("t1_busy_before_pop", 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        chk("t1_busy_after_pop", 64'(busy), 64'd0);
        chk("t1_rsp_valid_after_pop", 64'(rsp_valid), 64'd0);

        // All requesters streaming with rsp_ready high
        do_reset();
        rsp_ready    = 1'b1;
        max_inflight = 0;
        exp_next     = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            rand_addrs();
            #1;
            if (req_ready != '0) begin
                chk("t2_rr_order", 64'(req_ready), 64'(1 << exp_next));
                exp_next = (exp_next + 1) % NUM_REQ;
            end
        end
        @(negedge clk);
        req_valid = '0;
        repeat (14) @(negedge clk);
        #1;
        chk("t2_max_inflight", 64'(max_inflight), 64'd8);
        chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("t2_busy_idle", 64'(busy), 64'd0);

        // Backpressure: requester 0 streams while rsp_ready is low
        do_reset();
        xfers = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            rand_addrs();
            #1;
            if (req_ready[0]) xfers++;
        end
        @(negedge clk);
        #1;
        chk("t3_xfers", 64'(xfers), 64'd8);
        chk("t3_stalled_ready", 64'(req_ready), 64'd0);
        chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t3_busy", 64'(busy), 64'd1);
`ifdef HASH_ARB_PERF_CNT_EN
        chk("t6_issue_cnt", 64'(issue_cnt), 64'd8);
        chk("t6_stall_cnt", 64'(stall_cnt), 64'd12);
`endif
        rsp_ready = 1'b1;
        xfers2 = 0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            req_valid = 4'b0001;
            rand_addrs();
            #1;
            if (req_ready[0]) xfers2++;
        end
        chk("t3_resume", 64'(xfers2 > 0), 64'd1);
        @(negedge clk);
        req_valid = '0;
        repeat (20) @(negedge clk);
        #1;
        chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("t3_busy_idle", 64'(busy), 64'd0);

        // Reset with 5 in flight and 2 buffered
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            rand_addrs();
        end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("t5_pre_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t5_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_hash_addr", 64'(hash_addr), 64'd0);
`ifdef HASH_ARB_PERF_CNT_EN
        chk("t6_rst_issue_cnt", 64'(issue_cnt), 64'd0);
        chk("t6_rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        rand_addrs();
        #1;
        chk("t5_first_grant", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("t5_busy_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hash_pipe_arbiter.md
Name: hash_pipe_arbiter

Overview:
Shares one fully pipelined single-hash unit between NUM_REQ requesters in the count-min sketch datapath. The hash unit has no valid or backpressure of its own, so this block does that work:
- Round-robin arbitration at one issue per cycle.
- Drives the hash unit address.
- Tracks valid and requester ID through a shift register aligned to the hash latency.
- Returns results through a credit-protected output FIFO with a valid/ready interface.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDR_SIZE, 22, request address width
W, 4096, sketch row width
HASH_SIZE, $clog2(W), hash value width
HASH_LATENCY, 6, cycles from hash unit input sample edge to hash_value update
FIFO_DEPTH, 8, output FIFO entries (power of 2, >= 2)
ID_W, $clog2(NUM_REQ), requester ID width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_addr  in  NUM_REQ*ADDR_SIZE  packed addresses; requester i uses bits [i*ADDR_SIZE +: ADDR_SIZE]
req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
hash_addr  out  ADDR_SIZE  registered address to the hash unit input_addr
hash_value  in  HASH_SIZE  hash unit result
rsp_valid  out  1  FIFO head valid
rsp_ready  in  1  downstream accept
rsp_id  out  ID_W  requester ID of the head entry
rsp_addr  out  ADDR_SIZE  original address of the head entry
rsp_hash  out  HASH_SIZE  hash of the head entry
busy  out  1  high when any request is in flight or the FIFO is non-empty

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - On reset, all outputs are 0 and the FIFO is empty.
  - The valid shift register and credit counter clear; the RR pointer is set so requester 0 has top priority.
- Arbitration:
  - Search starts at (last_grant+1) mod NUM_REQ; the first asserted req_valid wins.
  - req_ready is combinational from req_valid, the pointer and credit_ok. At most one bit is high.
  - Requesters must not derive req_valid from req_ready.
  - The pointer updates only on a transfer.
- Credits:
  - used_cnt ranges 0..FIFO_DEPTH and counts in-flight requests plus FIFO occupancy.
  - credit_ok = used_cnt < FIFO_DEPTH.
  - used_cnt does +1 on a grant and -1 on a pop. A simultaneous grant and pop leaves it unchanged.
  - Consequence: FIFO push never occurs when the FIFO is full.
- Issue:
  - On a grant at edge T: hash_addr <= selected addr; stage0 <= {1, id, addr}.
  - With no grant: hash_addr <= 0 and stage0 valid <= 0.
- Alignment:
  - The shift register has stages 0..HASH_LATENCY, each holding {valid, id, addr}, and shifts every cycle.
  - The stage HASH_LATENCY entry is valid in the same cycle that hash_value holds its result (edge T+6).
  - That entry plus hash_value is pushed into the FIFO at edge T+7.
- FIFO:
  - Registered, not fall-through. rsp_* come from the head register and rsp_valid = !empty.
  - Pop on rsp_valid & rsp_ready. Push and pop in the same cycle are both honoured.
  - Pushing into an empty FIFO makes rsp_valid high the next cycle.
- Latency and throughput:
  - Acceptance edge T -> rsp_valid high from edge T+HASH_LATENCY+1 (7 cycles).
  - Steady-state throughput is 1 per cycle when rsp_ready is held high.
  - Responses leave in acceptance order.
- Reset mid-operation: in-flight and buffered entries are discarded. The hash unit shares rst_n.
- busy = (used_cnt != 0).

Optional Feature:
HASH_ARB_PERF_CNT_EN:
- Defined: adds output ports issue_cnt[31:0] and stall_cnt[31:0]. Both are saturating and reset to 0.
  - issue_cnt increments on each grant.
  - stall_cnt increments each cycle where |req_valid is high and credit_ok is low.
- Undefined: these ports and their logic are absent, and the behaviour is otherwise identical.

Test Plan:
1. Single request: req_valid[1]=1, addr 0x00001, rsp_ready=1.
   -> Grant at T; rsp_valid at T+7 with rsp_id=1, rsp_addr=0x00001, rsp_hash equal to the hash unit model output; busy low after the pop.
2. All 4 requesters valid continuously, rsp_ready=1.
   -> Grants follow 0,1,2,3,0,... with one per cycle; responses arrive back-to-back in the same ID order; used_cnt never exceeds 8.
3. rsp_ready=0 with requester 0 streaming.
   -> Exactly 8 transfers, then req_ready=0. Raising rsp_ready yields 8 ordered responses and issue resumes; nothing is lost or duplicated.
4. Fairness: last grant=2, then req_valid=4'b1001.
   -> Grant requester 3 first, then requester 0.
5. Reset mid-operation: assert rst_n with 5 in flight and 2 buffered.
   -> rsp_valid=0, busy=0, hash_addr=0 immediately. After release, req_valid=4'b1111 grants requester 0 first.
6. HASH_ARB_PERF_CNT_EN defined, scenario 3.
   -> issue_cnt=8 and stall_cnt equal to the stalled cycles with |req_valid high; both are 0 after reset.
